// File: rtl/fullchip_seq_if.sv
// Host-side bundle for the fullchip instruction sequencer: run control, input vector
// handshake, ofifo status and the registered memory/instruction outputs.
interface fullchip_seq_if #(
    parameter int unsigned bw = 4,
    parameter int unsigned pr = 8,
    parameter int unsigned aw = 4
);
    logic                 start;
    logic [aw:0]          q_count;
    logic [pr*bw-1:0]     in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 ofifo_valid;
    logic [pr*bw-1:0]     mem_in;
    logic [8+2*aw:0]      inst;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output start, q_count, in_data, in_valid, ofifo_valid,
        input  in_ready, mem_in, inst, busy, done, err
    );

    modport slave (
        input  start, q_count, in_data, in_valid, ofifo_valid,
        output in_ready, mem_in, inst, busy, done, err
    );
endinterface

// File: rtl/fullchip_seq.sv
// Instruction sequencer for fullchip: Q/K write, K load, execute and ofifo drain
// into psum memory, all generated from a single start pulse.
module fullchip_seq #(
    parameter int unsigned bw  = 4,
    parameter int unsigned pr  = 8,
    parameter int unsigned col = 8,
    parameter int unsigned aw  = 4,
    parameter int unsigned gap = 10
) (
    input logic           clk_i,
    input logic           rst_ni,
    fullchip_seq_if.slave bus
);
    localparam int unsigned InstW = 9 + 2 * aw;
    localparam int unsigned GapW  = $clog2(gap + 1);
    localparam int unsigned CntW  = (aw + 1 > GapW) ? aw + 1 : GapW;

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t        ColCnt  = cnt_t'(col);
    localparam cnt_t        GapLast = cnt_t'(gap - 1);
    localparam logic [aw:0] QMax    = {1'b1, {aw{1'b0}}};

    // Strobe byte: {execute, load, qmem_rd, qmem_wr, kmem_rd, kmem_wr, pmem_rd, pmem_wr}
    localparam logic [7:0] SQwr  = 8'h10;
    localparam logic [7:0] SKwr  = 8'h04;
    localparam logic [7:0] SLd   = 8'h40;
    localparam logic [7:0] SLdK  = 8'h48;
    localparam logic [7:0] SExec = 8'ha0;
    localparam logic [7:0] SPwr  = 8'h01;

    typedef enum logic [3:0] {
        StIdle, StQwr, StKwr, StPause, StKload, StKtail, StWait, StExec, StEtail, StDrain
    } state_e;

    state_e           st_q;
    cnt_t             cnt_q;
    logic [aw:0]      n_q;
    logic [InstW-1:0] inst_q;
    logic [pr*bw-1:0] mem_in_q;
    logic             done_q;
    logic             err_q;

    logic             in_ready;
    logic             beat;
    logic [aw-1:0]    cnt_add;
    logic [aw-1:0]    qk_hold;
    logic [aw-1:0]    p_hold;

    function automatic logic [InstW-1:0] mk_inst(input logic          ofrd,
                                                 input logic [aw-1:0] qk,
                                                 input logic [aw-1:0] pa,
                                                 input logic [7:0]    strb);
        return {ofrd, qk, pa, strb};
    endfunction

    // The extra cycle with cnt at its limit is the all-zero tail after each write phase.
    assign in_ready = (st_q == StQwr && cnt_q != cnt_t'(n_q)) ||
                      (st_q == StKwr && cnt_q != ColCnt);
    assign beat     = in_ready & bus.in_valid;
    assign cnt_add  = cnt_q[aw-1:0];
    assign qk_hold  = inst_q[8+2*aw-1:8+aw];
    assign p_hold   = inst_q[8+aw-1:8];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q     <= StIdle;
            cnt_q    <= '0;
            n_q      <= '0;
            inst_q   <= '0;
            mem_in_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            inst_q <= '0;
            if (beat) mem_in_q <= bus.in_data;
            case (st_q)
                StIdle: begin
                    if (bus.start) begin
                        if (bus.q_count != '0 && bus.q_count <= QMax) begin
                            n_q   <= bus.q_count;
                            cnt_q <= '0;
                            st_q  <= StQwr;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StQwr, StKwr: begin
                    if (!in_ready) begin
                        cnt_q <= '0;
                        st_q  <= (st_q == StQwr) ? StKwr : StPause;
                    end else if (beat) begin
                        inst_q <= mk_inst(1'b0, cnt_add, '0, (st_q == StQwr) ? SQwr : SKwr);
                        cnt_q  <= cnt_q + cnt_t'(1);
                    end else begin
                        inst_q <= mk_inst(1'b0, qk_hold, '0, '0);
                    end
                end
                StPause: begin
                    if (cnt_q == cnt_t'(1)) begin
                        cnt_q <= '0;
                        st_q  <= StKload;
                    end else begin
                        cnt_q <= cnt_q + cnt_t'(1);
                    end
                end
                StKload: begin
                    inst_q <= mk_inst(1'b0, (cnt_q < cnt_t'(2)) ? '0 : cnt_add - aw'(1), '0,
                                      (cnt_q == '0) ? SLd : SLdK);
                    if (cnt_q == ColCnt) begin
                        cnt_q <= '0;
                        st_q  <= StKtail;
                    end else begin
                        cnt_q <= cnt_q + cnt_t'(1);
                    end
                end
                StKtail: begin
                    if (cnt_q == '0) begin
                        inst_q <= mk_inst(1'b0, '0, '0, SLd);
                        cnt_q  <= cnt_t'(1);
                    end else begin
                        cnt_q <= '0;
                        st_q  <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == GapLast) begin
                        cnt_q <= '0;
                        st_q  <= StExec;
                    end else begin
                        cnt_q <= cnt_q + cnt_t'(1);
                    end
                end
                StExec: begin
                    inst_q <= mk_inst(1'b0, cnt_add, '0, SExec);
                    if (cnt_q == cnt_t'(n_q) - cnt_t'(1)) begin
                        cnt_q <= '0;
                        st_q  <= StEtail;
                    end else begin
                        cnt_q <= cnt_q + cnt_t'(1);
                    end
                end
                StEtail: begin
                    st_q <= StDrain;
                end
                StDrain: begin
                    if (bus.ofifo_valid) begin
                        inst_q <= mk_inst(1'b1, '0, cnt_add, SPwr);
                        if (cnt_q == cnt_t'(n_q) - cnt_t'(1)) begin
                            cnt_q  <= '0;
                            done_q <= 1'b1;
                            st_q   <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + cnt_t'(1);
                        end
                    end else begin
                        inst_q <= mk_inst(1'b0, '0, p_hold, '0);
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.mem_in   = mem_in_q;
    assign bus.inst     = inst_q;
    assign bus.busy     = (st_q != StIdle);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: doc/fullchip_seq.md
# fullchip_seq

Parametrised instruction sequencer for `fullchip`. It replaces the hand-stepped bench sequence with on-chip control: Q write, K write, K load, execute, then output-FIFO drain into psum memory, all generated from one `start` pulse. Q/K vectors stream in from a host through a valid/ready handshake. It adds three things: a runtime Q-vector count, backpressure on input data, and an ofifo-valid-gated drain in place of fixed wait cycles.

## Interface
- `bw`, 4, Q/K element width
- `pr`, 8, elements per vector
- `col`, 8, K vectors (dot-product units); must be ≤ 2^`aw`
- `aw`, 4, qk/pmem address width; Q depth = 2^`aw`
- `gap`, 10, idle cycles after K load

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared while low
- `start`  in  1  begin a run; sampled only in IDLE
- `q_count`  in  `aw`+1  Q vectors for this run, latched at start; legal 1..2^`aw`
- `in_data`  in  `pr`*`bw`  host vector, element j at bits [(j+1)*bw-1 : j*bw]
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  sequencer accepts `in_data` this cycle
- `ofifo_valid`  in  1  output FIFO holds at least one row
- `mem_in`  out  `pr`*`bw`  registered copy of the accepted `in_data`
- `inst`  out  9+2*`aw`  registered: {ofifo_rd, qkmem_add[aw], pmem_add[aw], execute, load, qmem_rd, qmem_wr, kmem_rd, kmem_wr, pmem_rd, pmem_wr}; `aw`=4 gives the 17-bit fullchip layout
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse on the transition DRAIN→IDLE
- `err`  out  1  one-cycle pulse when `start` is seen with an illegal `q_count`

## Operation
- States, in order: IDLE → QWR → KWR → PAUSE → KLOAD → KTAIL → WAIT → EXEC → ETAIL → DRAIN → IDLE.
- IDLE
  - `start` with legal `q_count`: latch N = `q_count`, go to QWR.
  - `start` with illegal `q_count` (0 or > 2^`aw`): pulse `err`, stay in IDLE.
- QWR
  - `in_ready`=1.
  - Each accepted beat (valid & ready) writes the beat to `mem_in` and emits qmem_wr=1 at qkmem_add = beat index 0..N-1.
  - A non-accepted cycle emits qmem_wr=0, and the address holds.
  - After N beats: one cycle with all `inst` = 0, then KWR.
- KWR: same as QWR with kmem_wr, `col` beats, address 0..`col`-1. After `col` beats: one all-zero cycle, then PAUSE.
- PAUSE: 2 cycles, `inst` = 0.
- KLOAD: `col`+1 cycles, index i = 0..`col`.
  - load=1 throughout.
  - kmem_rd=1 for i ≥ 1.
  - qkmem_add = 0 for i ≤ 1, i−1 for i ≥ 2.
- KTAIL: 2 cycles.
  - Cycle 1: load=1, kmem_rd=0, add=0.
  - Cycle 2: `inst` = 0.
- WAIT: `gap` cycles, `inst` = 0.
- EXEC: N cycles, execute=1, qmem_rd=1, qkmem_add = 0..N−1.
- ETAIL: 1 cycle, `inst` = 0.
- DRAIN: N transfers.
  - A transfer happens only in a cycle where `ofifo_valid`=1. That cycle emits ofifo_rd=1, pmem_wr=1, pmem_add = transfer index 0..N−1.
  - A cycle with `ofifo_valid`=0 emits both strobes 0, and `pmem_add` holds the last value.
  - After the N-th transfer: pulse `done`, `inst` = 0, go to IDLE.
- Never asserted: pmem_rd, and in_ready outside QWR/KWR.
- Counters: an `aw`+1-bit beat counter, compared against N or `col`. Addresses are its low `aw` bits, so N = 2^`aw` reaches address 2^`aw`−1 without wrapping.

## Timing
- Reset (`reset` low): asynchronously forces IDLE, `inst` = 0, `mem_in` = 0, `in_ready`/`busy`/`done`/`err` = 0, all counters = 0.
- Reset mid-run aborts the run. After release the block idles until a new `start`.
- `inst` and `mem_in` are registered.
  - An input beat accepted at edge k appears on `mem_in` and `inst` in cycle k+1. Downstream memories therefore see data and strobe together in the same cycle.
- `in_ready` is a combinational function of state only. It never depends on `in_valid`.
- `busy` rises the cycle after `start` is accepted and falls in the same cycle `done` pulses.
- `start` while busy is ignored.
- Minimum run length with no input or ofifo stalls:
  - total = (N+1) + (`col`+1) + 2 + (`col`+1) + 2 + `gap` + N + 1 + N cycles
  - N = 8 with defaults: 9 + 9 + 2 + 9 + 2 + 10 + 8 + 1 + 8 = 58 cycles from the `start` edge to the `done` pulse.
- `ofifo_valid` is sampled combinationally in DRAIN; its deassertion stalls in the same cycle.

## Test plan
- Default parameters, N = 8, `in_valid` held high, `ofifo_valid` high.
  - qmem_wr at addresses 0..7 with Q[0..7] on `mem_in`, then kmem_wr at 0..7.
  - load window 9 cycles, kmem_rd addresses 0,0,1..7.
  - execute at 0..7; 8 drain strobes at pmem 0..7.
  - `done` 58 cycles after `start`.
- N = 3, `in_valid` toggling 1,0,1,0: only accepted beats produce qmem_wr, addresses 0,1,2 with no gaps in address sequence; K phase stretches identically.
- `ofifo_valid` low for drain cycles 2–4: ofifo_rd/pmem_wr = 0 and `pmem_add` holds at 1 during the stall; all 8 transfers complete to address 7; `done` delayed 3 cycles.
- `q_count` = 0, then 17 (with `aw` = 4): `err` pulses each time, `busy` stays 0; then `q_count` = 16 runs fully and the last qmem_wr and pmem_wr addresses are 15.
- `reset` asserted low in the middle of EXEC: `inst` = 0 immediately (asynchronously), `busy` = 0; after release, a `start` with N = 2 runs a clean full sequence.
- `start` re-pulsed during KLOAD: no effect; exactly one `done`.
